// File: rtl/regfile_cmd_ctrl_if.sv
// Byte-link and register-file port bundle for regfile_cmd_ctrl.
// master = the command controller, slave = the link/register-file side.
interface regfile_cmd_ctrl_if;
    // Host receive byte stream
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    // Readback transmit byte stream
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    // Register file write port
    logic [7:0] write_addr;
    logic [7:0] write_data;
    logic       write;
    // Register file read port (read_data is registered: valid the cycle after read)
    logic [7:0] read_addr;
    logic       read;
    logic [7:0] read_data;

    modport master (
        input  rx_data, rx_valid, tx_ready, read_data,
        output rx_ready, tx_data, tx_valid,
               write_addr, write_data, write, read_addr, read
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, read_data,
        input  rx_ready, tx_data, tx_valid,
               write_addr, write_data, write, read_addr, read
    );
endinterface

// File: rtl/regfile_cmd_ctrl.sv
// Byte-serial command sequencer for the configuration register file.
// Commands: OP_WRITE addr data  -> one write strobe
//           OP_READ  addr       -> one read strobe, readback byte on tx
// Illegal addresses suppress the strobe and pulse err_addr; stalled
// partial commands are aborted after TIMEOUT_CYCLES idle cycles.
module regfile_cmd_ctrl #(
    parameter int         NUMREGS        = 16,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] OP_WRITE       = 8'h01,
    parameter logic [7:0] OP_READ        = 8'h02
) (
    input  logic               clk,
    input  logic               reset_n,
    regfile_cmd_ctrl_if.master bus,
    output logic               busy,
    output logic               err_opcode,
    output logic               err_addr,
    output logic               err_timeout,
    output logic [15:0]        cmd_count
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_DO_WRITE,
        S_DO_READ,
        S_WAIT_RD,
        S_SEND
    } state_e;

    state_e        state_q, state_d;
    logic          is_read_q, is_read_d;      // opcode of the command in flight
    logic          addr_ok_q, addr_ok_d;      // latched address is < NUMREGS
    logic [7:0]    cmd_addr_q, cmd_addr_d;    // write address awaiting its data byte
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    rd_addr_q, rd_addr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]   cmd_count_q, cmd_count_d;
    logic          err_opcode_q, err_opcode_d;
    logic          err_timeout_q, err_timeout_d;

    logic rx_ready_c;
    logic accept;
    logic addr_legal;

    assign accept     = bus.rx_valid && rx_ready_c;
    assign addr_legal = int'(bus.rx_data) < NUMREGS;

    // State and datapath registers; reset drops any command in flight.
    // NOTE: flops use <= so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            is_read_q     <= 1'b0;
            addr_ok_q     <= 1'b0;
            cmd_addr_q    <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_addr_q     <= '0;
            tx_data_q     <= '0;
            tmo_cnt_q     <= '0;
            cmd_count_q   <= '0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            addr_ok_q     <= addr_ok_d;
            cmd_addr_q    <= cmd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_addr_q     <= rd_addr_d;
            tx_data_q     <= tx_data_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_count_q   <= cmd_count_d;
            err_opcode_q  <= err_opcode_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Next-state and datapath update: command decode, address latching, timeout.
    always_comb begin
        // NOTE: every _d gets a default first, so no branch can leave one unassigned (no latch).
        state_d       = state_q;
        is_read_d     = is_read_q;
        addr_ok_d     = addr_ok_q;
        cmd_addr_d    = cmd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        rd_addr_d     = rd_addr_q;
        tx_data_d     = tx_data_q;
        tmo_cnt_d     = '0;
        cmd_count_d   = cmd_count_q;
        err_opcode_d  = 1'b0;
        err_timeout_d = 1'b0;

        // Inter-byte timeout; an accept in the expiry cycle wins.
        if ((state_q == S_GET_ADDR || state_q == S_GET_DATA) && !accept) begin
            if (tmo_cnt_q == TMO_LAST) begin
                err_timeout_d = 1'b1;
                state_d       = S_IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                        is_read_d = (bus.rx_data == OP_READ);
                        state_d   = S_GET_ADDR;
                    end else if (bus.rx_data != 8'h00) begin
                        err_opcode_d = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (accept) begin
                    addr_ok_d = addr_legal;
                    if (is_read_q) begin
                        rd_addr_d = bus.rx_data;
                        state_d   = S_DO_READ;
                    end else begin
                        cmd_addr_d = bus.rx_data;
                        state_d    = S_GET_DATA;
                    end
                end
            end
            S_GET_DATA: begin
                if (accept) begin
                    wr_addr_d = cmd_addr_q;
                    wr_data_d = bus.rx_data;
                    state_d   = S_DO_WRITE;
                end
            end
            S_DO_WRITE: begin
                if (addr_ok_q) cmd_count_d = cmd_count_q + 16'd1;
                state_d = S_IDLE;
            end
            S_DO_READ: begin
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                tx_data_d = addr_ok_q ? bus.read_data : 8'h00;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    if (addr_ok_q) cmd_count_d = cmd_count_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        rx_ready_c = (state_q == S_IDLE) || (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
        bus.write  = (state_q == S_DO_WRITE) && addr_ok_q;
        bus.read   = (state_q == S_DO_READ) && addr_ok_q;
        err_addr   = ((state_q == S_DO_WRITE) || (state_q == S_DO_READ)) && !addr_ok_q;
        bus.tx_valid = (state_q == S_SEND);
        busy       = (state_q != S_IDLE);
    end

    assign bus.rx_ready   = rx_ready_c;
    assign bus.tx_data    = tx_data_q;
    assign bus.write_addr = wr_addr_q;
    assign bus.write_data = wr_data_q;
    assign bus.read_addr  = rd_addr_q;
    assign err_opcode     = err_opcode_q;
    assign err_timeout    = err_timeout_q;
    assign cmd_count      = cmd_count_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Testbench for regfile_cmd_ctrl: directed command streams; expected strobes,
// error pulses and readback bytes are queued by the stimulus and consumed by
// a monitor whenever the DUT presents one.
module tb_regfile_cmd_ctrl;

    localparam int NUMREGS = 16;
    localparam int TMO     = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy, err_opcode, err_addr, err_timeout;
    logic [15:0] cmd_count;

    regfile_cmd_ctrl_if bus();

    regfile_cmd_ctrl #(
        .NUMREGS       (NUMREGS),
        .TIMEOUT_CYCLES(TMO),
        .OP_WRITE      (8'h01),
        .OP_READ       (8'h02)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .busy       (busy),
        .err_opcode (err_opcode),
        .err_addr   (err_addr),
        .err_timeout(err_timeout),
        .cmd_count  (cmd_count)
    );

    always #5 clk = ~clk;

    // Register file model: write on strobe, registered readback.
    logic [7:0] regs [NUMREGS];
    always @(posedge clk) begin
        if (bus.write) regs[bus.write_addr[3:0]] <= bus.write_data;
        if (bus.read)  bus.read_data <= regs[bus.read_addr[3:0]];
    end

    typedef enum logic [2:0] {
        EV_WRITE = 3'd1, EV_READ, EV_ERR_OP, EV_ERR_ADDR, EV_ERR_TMO, EV_TX
    } ev_kind_e;

    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_%s: got addr 0x%0h data 0x%0h, expected no event", k.name(), a, d);
        end else begin
            e = exp_q.pop_front();
            check({"event_", e.kind.name()}, 32'({k, a, d}), 32'({e.kind, e.a, e.d}));
        end
    endtask

    // Monitor: every strobe, error pulse and tx handshake consumes one expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.write)                  got_ev(EV_WRITE, bus.write_addr, bus.write_data);
            if (bus.read)                   got_ev(EV_READ, bus.read_addr, 8'h00);
            if (err_opcode)                 got_ev(EV_ERR_OP, 8'h00, 8'h00);
            if (err_addr)                   got_ev(EV_ERR_ADDR, 8'h00, 8'h00);
            if (err_timeout)                got_ev(EV_ERR_TMO, 8'h00, 8'h00);
            if (bus.tx_valid && bus.tx_ready) got_ev(EV_TX, 8'h00, bus.tx_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) check("rx_accept_timeout", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    // Wait (bounded) until the monitor has consumed every queued expectation.
    task automatic drain(input string name);
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_tx_valid(input string name);
        for (int n = 0; n < 10; n++) begin
            if (bus.tx_valid) break;
            tick(1);
        end
        check(name, 32'(bus.tx_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_strobes"}, 32'({bus.write, bus.read, bus.tx_valid}), 32'd0);
        check({tag, "_errs"}, 32'({err_opcode, err_addr, err_timeout}), 32'd0);
        check({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;

        // Reset state
        tick(3);
        check_reset_outputs("reset");
        check("reset_addrs", 32'({bus.write_addr, bus.write_data, bus.read_addr}), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Write 0xA5 to 0x05, then read it back
        send_byte(8'h01);
        send_byte(8'h05);
        expect_ev(EV_WRITE, 8'h05, 8'hA5);
        send_byte(8'hA5);
        check("write_latency", 32'(bus.write), 32'd1);
        drain("write_05");
        expect_ev(EV_READ, 8'h05, 8'h00);
        expect_ev(EV_TX, 8'h00, 8'hA5);
        send_byte(8'h02);
        send_byte(8'h05);
        check("tx_not_early_1", 32'(bus.tx_valid), 32'd0);
        tick(1);
        check("tx_not_early_2", 32'(bus.tx_valid), 32'd0);
        tick(1);
        check("read_latency", 32'(bus.tx_valid), 32'd1);
        drain("read_05");
        check("cmd_count_after_wr_rd", 32'(cmd_count), 32'd2);

        // Out-of-range addresses
        expect_ev(EV_ERR_ADDR, 8'h00, 8'h00);
        send3(8'h01, 8'h10, 8'hFF);
        drain("bad_write");
        expect_ev(EV_ERR_ADDR, 8'h00, 8'h00);
        expect_ev(EV_TX, 8'h00, 8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        drain("bad_read");
        check("cmd_count_after_bad_addr", 32'(cmd_count), 32'd2);

        // Bad opcode, then a normal write, then a NOP
        expect_ev(EV_ERR_OP, 8'h00, 8'h00);
        send_byte(8'h7E);
        expect_ev(EV_WRITE, 8'h03, 8'h3C);
        send3(8'h01, 8'h03, 8'h3C);
        drain("write_03");
        check("cmd_count_after_op_err", 32'(cmd_count), 32'd3);
        send_byte(8'h00);
        tick(2);
        check("nop_busy", 32'(busy), 32'd0);
        expect_ev(EV_READ, 8'h03, 8'h00);
        expect_ev(EV_TX, 8'h00, 8'h3C);
        send_byte(8'h02);
        send_byte(8'h03);
        drain("read_03");
        check("cmd_count_after_read_03", 32'(cmd_count), 32'd4);

        // Timeout in GET_DATA: aborts exactly TMO idle cycles after the address byte
        send_byte(8'h01);
        send_byte(8'h04);
        expect_ev(EV_ERR_TMO, 8'h00, 8'h00);
        tick(TMO - 1);
        check("tmo_not_early", 32'(busy), 32'd1);
        tick(1);
        check("tmo_busy_drop", 32'(busy), 32'd0);
        check("tmo_pulse", 32'(err_timeout), 32'd1);
        drain("timeout");
        expect_ev(EV_WRITE, 8'h04, 8'h11);
        send3(8'h01, 8'h04, 8'h11);
        drain("write_04");
        check("cmd_count_after_tmo", 32'(cmd_count), 32'd5);

        // Byte accepted in the expiry cycle wins over the timeout
        send_byte(8'h01);
        tick(TMO - 1);
        send_byte(8'h06);
        expect_ev(EV_WRITE, 8'h06, 8'h77);
        send_byte(8'h77);
        drain("expiry_accept");
        check("cmd_count_after_expiry", 32'(cmd_count), 32'd6);

        // Backpressure on tx
        bus.tx_ready = 1'b0;
        expect_ev(EV_READ, 8'h05, 8'h00);
        expect_ev(EV_TX, 8'h00, 8'hA5);
        send_byte(8'h02);
        send_byte(8'h05);
        wait_tx_valid("bp_tx_valid");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_data !== 8'hA5 || bus.rx_ready || !busy) bad++;
        end
        check("bp_hold_violations", 32'(bad), 32'd0);
        check("bp_count_held", 32'(cmd_count), 32'd6);
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        drain("bp_read");
        check("bp_busy_after", 32'(busy), 32'd0);
        check("cmd_count_after_bp", 32'(cmd_count), 32'd7);

        // Reset in GET_DATA: no write may follow
        send_byte(8'h01);
        send_byte(8'h02);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_getdata");
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("rst_getdata_idle", 32'(busy), 32'd0);

        // Reset in SEND
        bus.tx_ready = 1'b0;
        expect_ev(EV_READ, 8'h05, 8'h00);
        send_byte(8'h02);
        send_byte(8'h05);
        wait_tx_valid("rst_send_tx_valid");
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_send");
        tick(2);
        reset_n = 1'b1;
        bus.tx_ready = 1'b1;
        tick(2);
        check("rst_send_idle", 32'(busy), 32'd0);

        // Normal operation resumes
        expect_ev(EV_WRITE, 8'h07, 8'h5A);
        send3(8'h01, 8'h07, 8'h5A);
        drain("write_07");
        check("cmd_count_after_resets", 32'(cmd_count), 32'd1);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
